// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vend_dispenser block
package vend_pkg;

    localparam int CREDIT_W       = 2;
    localparam int DEBOUNCE_DEPTH = 3;

`ifdef VEND_CHANGE_RETURN_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_VEND,
        ST_CHANGE,
        ST_DENY
    } vend_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_VEND,
        ST_DENY
    } vend_state_e;
`endif

endpackage

// File: rtl/vend_debounce.sv
// rtl/vend_debounce.sv - select-button debouncer with one-cycle rising-edge pulse
module vend_debounce
    import vend_pkg::*;
(
    input  logic clk,
    input  logic rst_i,
    input  logic raw,
    output logic edge_pulse
);

    logic [DEBOUNCE_DEPTH-1:0] sync_q;
    logic                      deb_q;
    logic                      deb;

    // Debounced level needs every sample in the window high.
    assign deb        = &sync_q;
    assign edge_pulse = deb & ~deb_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEBOUNCE_DEPTH-2:0], raw};
            deb_q  <= deb;
        end
    end

endmodule

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - vending dispense controller; VEND_CHANGE_RETURN_EN enables coin change return
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int PRICE        = 2,
    parameter int MOTOR_CYCLES = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int DENY_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                sel_raw,
    input  logic [CREDIT_W-1:0] credit,
    output logic                credit_clr,
    output logic                motor,
    output logic                change_pulse,
    output logic                deny,
    output logic                busy
);

    if (PRICE < 1 || PRICE > 3) begin : g_bad_price
        $error("vend_dispenser: PRICE must be in 1..3");
    end
    if (MOTOR_CYCLES < 1 || MOTOR_CYCLES > 255) begin : g_bad_motor
        $error("vend_dispenser: MOTOR_CYCLES must be in 1..255");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
        $error("vend_dispenser: PULSE_CYCLES must be in 1..255");
    end
    if (DENY_CYCLES < 1 || DENY_CYCLES > 255) begin : g_bad_deny
        $error("vend_dispenser: DENY_CYCLES must be in 1..255");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [7:0]          MOTOR_LD = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0]          DENY_LD  = 8'(DENY_CYCLES - 1);

    logic        sel_edge;
    vend_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    vend_debounce u_debounce (
        .clk        (clk),
        .rst_i      (rst_i),
        .raw        (sel_raw),
        .edge_pulse (sel_edge)
    );

`ifdef VEND_CHANGE_RETURN_EN
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    logic [CREDIT_W-1:0] chg_q, chg_d;
    logic                phase_q, phase_d;
    logic                pulse_q;
`endif

    // Each state's counter is loaded on entry with (duration - 1) and the
    // state is left in the cycle the counter reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef VEND_CHANGE_RETURN_EN
        chg_d   = chg_q;
        phase_d = phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_edge) begin
                    if (credit >= PRICE_C) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
`ifdef VEND_CHANGE_RETURN_EN
                        chg_d   = credit - PRICE_C;
`endif
                    end else begin
                        state_d = ST_DENY;
                        cnt_d   = DENY_LD;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_VEND;
                cnt_d   = MOTOR_LD;
            end
            ST_VEND: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef VEND_CHANGE_RETURN_EN
                    if (chg_q != '0) begin
                        state_d = ST_CHANGE;
                        cnt_d   = PULSE_LD;
                        phase_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef VEND_CHANGE_RETURN_EN
            // phase_q high = pulse high half, low = spacing half of one unit.
            ST_CHANGE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (phase_q) begin
                    phase_d = 1'b0;
                    cnt_d   = PULSE_LD;
                end else begin
                    if (chg_q != '0) begin
                        chg_d = chg_q - 2'd1;
                    end
                    if (chg_q <= 2'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        phase_d = 1'b1;
                        cnt_d   = PULSE_LD;
                    end
                end
            end
`endif
            ST_DENY: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            credit_clr <= 1'b0;
            motor      <= 1'b0;
            deny       <= 1'b0;
            busy       <= 1'b0;
`ifdef VEND_CHANGE_RETURN_EN
            chg_q      <= '0;
            phase_q    <= 1'b0;
            pulse_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            credit_clr <= (state_d == ST_CLEAR);
            motor      <= (state_d == ST_VEND);
            deny       <= (state_d == ST_DENY);
            busy       <= (state_d != ST_IDLE);
`ifdef VEND_CHANGE_RETURN_EN
            chg_q      <= chg_d;
            phase_q    <= phase_d;
            pulse_q    <= (state_d == ST_CHANGE) && phase_d;
`endif
        end
    end

`ifdef VEND_CHANGE_RETURN_EN
    assign change_pulse = pulse_q;
`else
    assign change_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - randomized scoreboard bench for vend_dispenser
module tb_vend_dispenser;

    localparam int PRICE  = 2;
    localparam int MOTOR  = 8;
    localparam int PULSE  = 4;
    localparam int DENY_N = 4;
`ifdef VEND_CHANGE_RETURN_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    localparam int K_IDLE = 0;
    localparam int K_CLR  = 1;
    localparam int K_MOT  = 2;
    localparam int K_PUL  = 3;
    localparam int K_DEN  = 4;
    localparam int K_GAP  = 5;

    typedef struct {
        int kind;
        int len;
    } run_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       sel_raw = 1'b0;
    logic [1:0] credit = 2'd0;
    logic       credit_clr, motor, change_pulse, deny, busy;

    int   checks = 0;
    int   errors = 0;
    run_t exp_q[$];
    int   cur_kind = K_IDLE;
    int   cur_len = 0;

    vend_dispenser #(
        .PRICE        (PRICE),
        .MOTOR_CYCLES (MOTOR),
        .PULSE_CYCLES (PULSE),
        .DENY_CYCLES  (DENY_N)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .sel_raw      (sel_raw),
        .credit       (credit),
        .credit_clr   (credit_clr),
        .motor        (motor),
        .change_pulse (change_pulse),
        .deny         (deny),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic string kname(int k);
        case (k)
            K_CLR:   return "credit_clr";
            K_MOT:   return "motor";
            K_PUL:   return "change_pulse";
            K_DEN:   return "deny";
            K_GAP:   return "busy_gap";
            default: return "idle";
        endcase
    endfunction

    // Expected activity of one accepted select, as runs of output levels.
    task automatic push_txn(int c);
        int k;
        if (c >= PRICE) begin
            exp_q.push_back('{K_CLR, 1});
            exp_q.push_back('{K_MOT, MOTOR});
            k = CHG_EN ? c - PRICE : 0;
            for (int i = 0; i < k; i++) begin
                exp_q.push_back('{K_PUL, PULSE});
                exp_q.push_back('{K_GAP, PULSE});
            end
        end else begin
            exp_q.push_back('{K_DEN, DENY_N});
        end
    endtask

    task automatic check_run(int k, int l);
        run_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_run got %s x%0d required none", kname(k), l);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.len != l) begin
                errors++;
                $display("FAIL run got %s x%0d required %s x%0d", kname(k), l, kname(e.kind), e.len);
            end
        end
    endtask

    // Monitor: compresses output activity into runs and checks each finished run.
    always @(negedge clk) begin
        int k;
        int n_on;
        if (rst_i) begin
            cur_kind = K_IDLE;
            cur_len  = 0;
        end else begin
            n_on = int'(credit_clr) + int'(motor) + int'(change_pulse) + int'(deny);
            checks++;
            if (n_on > 1 || (n_on == 1 && !busy)) begin
                errors++;
                $display("FAIL exclusive got clr=%b mot=%b pul=%b den=%b busy=%b required one-hot under busy",
                         credit_clr, motor, change_pulse, deny, busy);
            end
            if (credit_clr)        k = K_CLR;
            else if (motor)        k = K_MOT;
            else if (change_pulse) k = K_PUL;
            else if (deny)         k = K_DEN;
            else if (busy)         k = K_GAP;
            else                   k = K_IDLE;
            if (k != cur_kind) begin
                if (cur_kind != K_IDLE) check_run(cur_kind, cur_len);
                cur_kind = k;
                cur_len  = 1;
            end else begin
                cur_len++;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(int h, int c);
        credit  = 2'(c);
        sel_raw = 1'b1;
        tick(h);
        sel_raw = 1'b0;
        credit  = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout got busy=1 required busy=0", tag);
        end
    endtask

    task automatic wait_motor(string tag);
        int n = 0;
        while (!motor && n < 30) begin
            tick(1);
            n++;
        end
        checks++;
        if (!motor) begin
            errors++;
            $display("FAIL %s_motor_timeout got motor=0 required motor=1", tag);
        end
    endtask

    task automatic expect_quiet(string tag, int n);
        bit saw = 1'b0;
        repeat (n) begin
            tick(1);
            if (busy) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL %s got busy=1 required busy=0", tag);
        end
    endtask

    task automatic check_zero(string tag);
        logic [4:0] got;
        got = {credit_clr, motor, change_pulse, deny, busy};
        checks++;
        if (got != 5'b0) begin
            errors++;
            $display("FAIL %s got outputs=%b required 00000", tag, got);
        end
    endtask

    task automatic do_normal(int c, int h);
        push_txn(c);
        press(h, c);
        tick(2);
        wait_idle("normal");
        tick(3);
    endtask

    task automatic do_double(int c);
        push_txn(c);
        press(5, c);
        wait_motor("double");
        press(4, $urandom_range(0, 3));
        tick(2);
        wait_idle("double");
        tick(3);
    endtask

    task automatic do_held(int c);
        push_txn(c);
        credit  = 2'(c);
        sel_raw = 1'b1;
        tick(5);
        credit  = 2'($urandom_range(0, 3));
        wait_idle("held");
        tick(10);
        sel_raw = 1'b0;
        tick(3);
    endtask

    initial begin
        int sc;
        int c;
        tick(3);
        check_zero("reset_state");
        rst_i = 1'b0;
        tick(1);
        check_zero("post_reset");

        do_normal(3, 5);
        do_normal(1, 5);
        press(2, 3);
        expect_quiet("short_press", 10);
        do_double(2);
        do_held(3);

        // Reset on the fourth motor cycle must abort with no resumption.
        push_txn(3);
        press(5, 3);
        wait_motor("reset_mid");
        tick(3);
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check_zero("async_abort");
        exp_q.delete();
        tick(3);
        rst_i = 1'b0;
        tick(1);
        check_zero("abort_release");
        expect_quiet("no_resume", 30);

        for (int i = 0; i < 30; i++) begin
            sc = $urandom_range(0, 3);
            c  = $urandom_range(0, 3);
            case (sc)
                0: do_normal(c, $urandom_range(3, 6));
                1: begin
                    press($urandom_range(1, 2), c);
                    expect_quiet("rand_short", 8);
                end
                2: do_double($urandom_range(PRICE, 3));
                default: do_held(c);
            endcase
        end

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d runs pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
